reg_writeback_arbiter: RTL
==========================

Name: reg_writeback_arbiter

Overview:
- Writer-side counterpart of the 32 x 64-bit integer register file.
- Merges two result sources onto the register file's single write port: the single-cycle ALU result and the variable-latency load response from data memory.
- Load results are sign- or zero-extended per RV64I load type and buffered in a small FIFO, so late memory responses never collide with ALU writebacks.
- Drives the register file's RegWrite, write_reg_addr and write_reg_data inputs directly.

Parameters:
- DATA_WIDTH, 64, register and data width.
- ADDR_WIDTH, 5, register index width.
- FIFO_DEPTH, 4, load-writeback buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU result accepted when alu_valid && alu_ready.
- alu_rd  in  ADDR_WIDTH  ALU destination register.
- alu_data  in  DATA_WIDTH  ALU result.
- ld_valid  in  1  load response offered.
- ld_ready  out  1  load accepted when ld_valid && ld_ready.
- ld_rd  in  ADDR_WIDTH  load destination register.
- ld_funct3  in  3  load type.
- ld_data  in  DATA_WIDTH  raw 64-bit memory doubleword; the addressed bytes are already aligned to bit 0.
- reg_write  out  1  register-file write enable.
- write_reg_addr  out  ADDR_WIDTH  write address.
- write_reg_data  out  DATA_WIDTH  write data.
- ld_err  out  1  one-cycle pulse on an illegal funct3.
- fifo_count  out  clog2(FIFO_DEPTH)+1  occupied entries.
- busy  out  1  fifo_count != 0.

Behaviour:
- Reset (synchronous, active-high):
  - reg_write, write_reg_addr, write_reg_data, ld_err are 0; FIFO is emptied (pointers and count 0).
  - A reset asserted mid-operation discards all pending loads and any in-flight write.
  - No write is issued in the cycle following a reset edge.
- Handshakes (combinational from registered state):
  - alu_ready = (fifo_count != FIFO_DEPTH).
  - ld_ready = (fifo_count != FIFO_DEPTH).
  - No push-while-full bypass.
- Arbitration, decided at each rising edge:
  - If the ALU handshake fires, the ALU wins the port.
  - Otherwise, if the FIFO is non-empty, pop the head.
  - Because alu_ready is low when the FIFO is full, a full FIFO always drains.
- Output registers:
  - The winner's rd/data are registered into write_reg_addr/write_reg_data, and reg_write is set to 1 for exactly one cycle.
  - With no winner, reg_write = 0 and addr/data hold their previous values.
- Latency:
  - ALU: accepted at edge E, so reg_write is high in the cycle after E.
  - Load: pushed at edge E, earliest pop at E+1, so the write is visible after E+1.
- Simultaneous push and pop in the same edge is allowed; fifo_count is unchanged.
- Load extension is applied at push time; the FIFO stores the final 64-bit value plus rd:
  - 000 LB: sign-extend bits [7:0].
  - 001 LH: sign-extend bits [15:0].
  - 010 LW: sign-extend bits [31:0].
  - 011 LD: raw.
  - 100 LBU: zero-extend bits [7:0].
  - 101 LHU: zero-extend bits [15:0].
  - 110 LWU: zero-extend bits [31:0].
  - 111 illegal: handshake completes, nothing is enqueued, and ld_err pulses high in the following cycle.
- x0 handling:
  - An ALU result with alu_rd == 0 is consumed but does not win the port, so the FIFO may pop in that edge; no write occurs for it.
  - A load with ld_rd == 0 is consumed and not enqueued.
  - reg_write is never asserted with write_reg_addr == 0.
- Ordering:
  - Loads are written in acceptance order.
  - No ordering is enforced between the ALU and load streams; hazards are the pipeline's responsibility.
- FIFO pointers wrap modulo FIFO_DEPTH; fifo_count never exceeds FIFO_DEPTH.

Test Plan:
1. Reset, then ALU rd=5 data=0x1234 for one cycle -> next cycle reg_write=1, addr=5, data=0x1234; following cycle reg_write=0, addr/data hold.
2. LB rd=3 ld_data=0x80 with ALU idle -> fifo_count=1, then a write of addr=3 data=0xFFFFFFFFFFFFFF80. Repeat with LBU, LHU 0x8000, LWU 0x80000000, LW 0x80000000 -> zero/sign-extended values respectively.
3. ALU valid every cycle (rd=1..) while 5 loads arrive back-to-back -> 4 loads buffered, alu_ready drops at count=4, a load write occurs, and alu_ready re-rises. All 5 loads are written in order; no ALU result is lost.
4. ALU rd=0 together with a pending load rd=7 -> the load pops that edge, writes addr=7, and there is no write to x0. Load with rd=0 -> fifo_count unchanged.
5. ld_funct3=111 -> fifo_count unchanged, ld_err high for one cycle, no write.
6. FIFO holding 3 entries, reset asserted for one cycle -> fifo_count=0, busy=0, reg_write=0, no stale writes afterwards.

Source files
------------

// File: rtl/reg_writeback_arbiter.sv
// Merges the single-cycle ALU result and buffered, extended load responses onto
// the register file's single write port. The ALU has priority and loads wait in a small FIFO.
module reg_writeback_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [ADDR_WIDTH-1:0]         alu_rd,
    input  logic [DATA_WIDTH-1:0]         alu_data,
    input  logic                          ld_valid,
    output logic                          ld_ready,
    input  logic [ADDR_WIDTH-1:0]         ld_rd,
    input  logic [2:0]                    ld_funct3,
    input  logic [DATA_WIDTH-1:0]         ld_data,
    output logic                          reg_write,
    output logic [ADDR_WIDTH-1:0]         write_reg_addr,
    output logic [DATA_WIDTH-1:0]         write_reg_data,
    output logic                          ld_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0] fifo_rd   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    logic alu_fire, alu_win, ld_fire, ld_illegal, push, pop;

    function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [2:0] funct3,
                                                          input logic [DATA_WIDTH-1:0] raw);
        logic [DATA_WIDTH-1:0] ext;
        ext = raw;
        case (funct3)
            3'b000:  ext = {{(DATA_WIDTH-8){raw[7]}}, raw[7:0]};
            3'b001:  ext = {{(DATA_WIDTH-16){raw[15]}}, raw[15:0]};
            3'b010:  ext = {{(DATA_WIDTH-32){raw[31]}}, raw[31:0]};
            3'b100:  ext = {{(DATA_WIDTH-8){1'b0}}, raw[7:0]};
            3'b101:  ext = {{(DATA_WIDTH-16){1'b0}}, raw[15:0]};
            3'b110:  ext = {{(DATA_WIDTH-32){1'b0}}, raw[31:0]};
            default: ext = raw;
        endcase
        return ext;
    endfunction

    // Handshake: a transfer happens on a rising edge where valid && ready. Both
    // readies depend only on the registered count, so a full FIFO stalls both
    // streams and the head is guaranteed to drain on that edge.
    assign alu_ready  = (count != FULL_COUNT);
    assign ld_ready   = (count != FULL_COUNT);
    assign fifo_count = count;
    assign busy       = (count != '0);

    always_comb begin
        alu_fire   = alu_valid && alu_ready;
        alu_win    = alu_fire && (alu_rd != '0);
        ld_fire    = ld_valid && ld_ready;
        ld_illegal = ld_fire && (ld_funct3 == 3'b111);
        push       = ld_fire && !ld_illegal && (ld_rd != '0);
        pop        = !alu_win && (count != '0);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= ld_rd;
            fifo_data[wr_ptr] <= load_extend(ld_funct3, ld_data);
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Address and data hold their last value when nothing wins the port.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write      <= 1'b0;
            write_reg_addr <= '0;
            write_reg_data <= '0;
            ld_err         <= 1'b0;
        end else begin
            reg_write <= alu_win || pop;
            ld_err    <= ld_illegal;
            if (alu_win) begin
                write_reg_addr <= alu_rd;
                write_reg_data <= alu_data;
            end else if (pop) begin
                write_reg_addr <= fifo_rd[rd_ptr];
                write_reg_data <= fifo_data[rd_ptr];
            end
        end
    end

endmodule
